// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
//   seq_state_t : sequencer FSM states (RUN, TRAP)
//   TRAP_*      : trap_cause encodings
//   DEFAULT_ADDR_W : default PC / return-address width
package pc_seq_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 19;

    localparam logic [1:0] TRAP_NONE = 2'b00;
    localparam logic [1:0] TRAP_OVF  = 2'b01;
    localparam logic [1:0] TRAP_UDF  = 2'b10;

    typedef enum logic {
        RUN,
        TRAP
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Hardware return-address stack (DEPTH x WIDTH), storage not reset.
//   clk, rst : clock, synchronous active-high reset (clears count only)
//   push     : write wdata on top, ignored when full
//   pop      : drop top entry, ignored when empty
//   wdata    : return address to push
//   rdata    : current top entry (combinational, meaningless when empty)
//   count    : occupancy 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
module ras_stack #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 19
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;

    // DEPTH is a power of 2, so the low bits of the count index the next free slot.
    assign wr_idx  = count_q[IDX_W-1:0];
    assign top_idx = wr_idx - IDX_W'(1);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[top_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (push && !full) begin
            count_q <= count_q + CNT_W'(1);
        end else if (pop && !empty) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: accepts one decoded control-flow op per handshake and
// updates the PC one cycle later (increment, jump, beq, bne, call, ret).
// Owns the return-address stack. Optional macro PC_SEQ_STACK_TRAP_EN turns
// stack overflow/underflow into a trap to TRAP_VEC held until trap_ack;
// without it overflow drops the push and underflow acts as a plain increment.
//   clk, rst            : clock, synchronous active-high reset
//   instr_valid/ready   : op handshake (ready = RUN and not stalled)
//   jump, beq, bne      : branch strobes, zero_flag selects beq/bne outcome
//   call, ret           : subroutine strobes (priority call > ret > jump > beq > bne)
//   target              : jump/branch/call destination
//   stall               : fetch backpressure, blocks acceptance
//   trap_ack            : handler acknowledge, leaves TRAP
//   pc_current, sp      : current PC, RAS occupancy
//   trap, trap_cause    : trap pending level and cause
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned        ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned        STACK_DEPTH = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter logic [ADDR_W-1:0]  TRAP_VEC    = 19'h7FF00
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  logic                          jump,
    input  logic                          beq,
    input  logic                          bne,
    input  logic                          call,
    input  logic                          ret,
    input  logic                          zero_flag,
    input  logic [ADDR_W-1:0]             target,
    input  logic                          stall,
    input  logic                          trap_ack,
    output logic [ADDR_W-1:0]             pc_current,
    output logic [$clog2(STACK_DEPTH):0]  sp,
    output logic                          trap,
    output logic [1:0]                    trap_cause
);
    seq_state_t        state;
    logic              accept;
    logic              ras_full;
    logic              ras_empty;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_next;
    logic              trap_set;
    logic [1:0]        cause_next;

    assign instr_ready = (state == RUN) && !stall;
    assign accept      = instr_valid && instr_ready;
    assign pc_inc      = pc_current + ADDR_W'(1);

    // The stack ignores a push when full and a pop when empty, so the
    // overflow/underflow cases need no extra gating here.
    ras_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (accept && call),
        .pop   (accept && !call && ret),
        .wdata (pc_inc),
        .rdata (ras_top),
        .count (sp),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_comb begin
        pc_next    = pc_inc;
        trap_set   = 1'b0;
        cause_next = TRAP_NONE;
        if (call) begin
`ifdef PC_SEQ_STACK_TRAP_EN
            if (ras_full) begin
                pc_next    = TRAP_VEC;
                trap_set   = 1'b1;
                cause_next = TRAP_OVF;
            end else begin
                pc_next = target;
            end
`else
            pc_next = target;
`endif
        end else if (ret) begin
            if (ras_empty) begin
`ifdef PC_SEQ_STACK_TRAP_EN
                pc_next    = TRAP_VEC;
                trap_set   = 1'b1;
                cause_next = TRAP_UDF;
`else
                pc_next = pc_inc;
`endif
            end else begin
                pc_next = ras_top;
            end
        end else if (jump) begin
            pc_next = target;
        end else if (beq) begin
            pc_next = zero_flag ? target : pc_inc;
        end else if (bne) begin
            pc_next = !zero_flag ? target : pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pc_current <= RESET_PC;
            trap       <= 1'b0;
            trap_cause <= TRAP_NONE;
        end else begin
            case (state)
                RUN: begin
                    if (accept) begin
                        pc_current <= pc_next;
                        if (trap_set) begin
                            state      <= TRAP;
                            trap       <= 1'b1;
                            trap_cause <= cause_next;
                        end
                    end
                end
                TRAP: begin
                    pc_current <= TRAP_VEC;
                    if (trap_ack) begin
                        state      <= RUN;
                        trap       <= 1'b0;
                        trap_cause <= TRAP_NONE;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    localparam int unsigned AW    = 19;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned MASK  = 32'h7FFFF;
    localparam int unsigned TVEC  = 32'h7FF00;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic          jump = 1'b0, beq = 1'b0, bne = 1'b0, call = 1'b0, ret = 1'b0;
    logic          zero_flag = 1'b0;
    logic [AW-1:0] target = '0;
    logic          stall = 1'b0;
    logic          trap_ack = 1'b0;
    logic [AW-1:0] pc_current;
    logic [4:0]    sp;
    logic          trap;
    logic [1:0]    trap_cause;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump        (jump),
        .beq         (beq),
        .bne         (bne),
        .call        (call),
        .ret         (ret),
        .zero_flag   (zero_flag),
        .target      (target),
        .stall       (stall),
        .trap_ack    (trap_ack),
        .pc_current  (pc_current),
        .sp          (sp),
        .trap        (trap),
        .trap_cause  (trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned pc;
        int unsigned sp;
        int unsigned trap;
        int unsigned cause;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: PC, a queue as the return stack, trap status.
    int unsigned m_pc = 0;
    int unsigned m_ras[$];
    bit          m_in_trap = 1'b0;
    int unsigned m_cause = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic enter_trap(input int unsigned cause);
        m_pc      = TVEC;
        m_in_trap = 1'b1;
        m_cause   = cause;
    endtask

    task automatic model_op(input bit c, r, j, bq, bn, z, input int unsigned t);
        int unsigned inc;
        inc = (m_pc + 1) & MASK;
        if (c) begin
            if (m_ras.size() == DEPTH) begin
`ifdef PC_SEQ_STACK_TRAP_EN
                enter_trap(1);
`else
                m_pc = t;
`endif
            end else begin
                m_ras.push_back(inc);
                m_pc = t;
            end
        end else if (r) begin
            if (m_ras.size() == 0) begin
`ifdef PC_SEQ_STACK_TRAP_EN
                enter_trap(2);
`else
                m_pc = inc;
`endif
            end else begin
                m_pc = m_ras.pop_back();
            end
        end else if (j) begin
            m_pc = t;
        end else if (bq) begin
            m_pc = z ? t : inc;
        end else if (bn) begin
            m_pc = !z ? t : inc;
        end else begin
            m_pc = inc;
        end
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.pc    = m_pc;
        e.sp    = m_ras.size();
        e.trap  = m_in_trap;
        e.cause = m_cause;
        return e;
    endfunction

    // One cycle: drive at negedge, predict, then check hold cycles directly;
    // state changes are queued for the monitor.
    task automatic step(input bit v, c, r, j, bq, bn, z, input int unsigned t,
                        input bit st, ack);
        bit   m_ready;
        bit   fire;
        exp_t e;
        @(negedge clk);
        instr_valid = v; call = c; ret = r; jump = j; beq = bq; bne = bn;
        zero_flag = z; target = AW'(t); stall = st; trap_ack = ack;
        #1;
        m_ready = !m_in_trap && !st;
        check("instr_ready", {31'd0, instr_ready}, {31'd0, m_ready});
        fire = (v && m_ready) || (m_in_trap && ack);
        if (fire) begin
            if (m_in_trap) begin
                m_in_trap = 1'b0;
                m_cause   = 0;
            end else begin
                model_op(c, r, j, bq, bn, z, t & MASK);
            end
            sb.push_back(model_snapshot());
        end
        @(posedge clk);
        #1;
        if (!fire) begin
            e = model_snapshot();
            check("hold_pc", {13'd0, pc_current}, e.pc);
            check("hold_sp", {27'd0, sp}, e.sp);
            check("hold_trap", {31'd0, trap}, e.trap);
        end
    endtask

    task automatic op(input bit c, r, j, bq, bn, z, input int unsigned t);
        step(1'b1, c, r, j, bq, bn, z, t, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        instr_valid = 1'b0; call = 1'b0; ret = 1'b0; jump = 1'b0; beq = 1'b0; bne = 1'b0;
        stall = 1'b0; trap_ack = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        m_pc = 0;
        m_ras.delete();
        m_in_trap = 1'b0;
        m_cause = 0;
        check("reset_pc", {13'd0, pc_current}, 32'd0);
        check("reset_sp", {27'd0, sp}, 32'd0);
        check("reset_trap", {31'd0, trap}, 32'd0);
        check("reset_cause", {30'd0, trap_cause}, 32'd0);
        rst = 1'b0;
    endtask

    // Monitor: pops an expectation whenever the DUT takes an op or an ack.
    initial begin
        bit   fire;
        exp_t e;
        forever begin
            @(posedge clk);
            fire = !rst && ((instr_valid && instr_ready) || (trap && trap_ack));
            #1;
            if (fire) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: handshake with no expectation at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("pc", {13'd0, pc_current}, e.pc);
                    check("sp", {27'd0, sp}, e.sp);
                    check("trap", {31'd0, trap}, e.trap);
                    check("trap_cause", {30'd0, trap_cause}, e.cause);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset then plain increments
        do_reset(2);
        repeat (5) op(0, 0, 0, 0, 0, 0, 0);

        // 2: call / ret round trip
        op(0, 0, 1, 0, 0, 0, 'h10);
        op(1, 0, 0, 0, 0, 0, 'h200);
        op(0, 1, 0, 0, 0, 0, 0);

        // 3: branches and stall
        op(0, 0, 0, 1, 0, 1, 'h40);
        op(0, 0, 0, 0, 1, 1, 'h80);
        repeat (3) step(1, 0, 0, 1, 0, 0, 0, 'h123, 1, 0);

        // 4: fill the stack, then one call too many
        for (int i = 0; i < 17; i++) op(1, 0, 0, 0, 0, 0, 'h1000 + i * 'h10);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        op(0, 0, 0, 0, 0, 0, 0);

        // 5: ret on empty stack, PC wrap, return-address wrap
        do_reset(1);
        op(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        op(0, 0, 1, 0, 0, 0, 'h7FFFF);
        op(0, 0, 0, 0, 0, 0, 0);
        op(0, 0, 1, 0, 0, 0, 'h7FFFF);
        op(1, 0, 0, 0, 0, 0, 'h100);
        op(0, 1, 0, 0, 0, 0, 0);

        // 6: call beats jump; reset while trapped
        op(1, 0, 1, 0, 0, 0, 'h300);
        do_reset(1);
        op(0, 1, 0, 0, 0, 0, 0);
        do_reset(1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 8, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, $urandom & MASK,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
        end

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
